// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FP issue controller.
package fpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_SQRT  = 4'd4,
        OP_SGNJ  = 4'd5,
        OP_SGNJN = 4'd6,
        OP_SGNJX = 4'd7,
        OP_MIN   = 4'd8,
        OP_MAX   = 4'd9
    } fp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    localparam logic [6:0] OPC_OP_FP = 7'b1010011;
    localparam logic [1:0] FMT_S     = 2'b00;
    localparam logic [2:0] RM_DYN    = 3'b111;

    // Static rounding modes 000..100 are defined; 101/110 are reserved.
    function automatic logic rm_is_valid(input logic [2:0] rm);
        return rm <= 3'b100;
    endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Instruction, FPU and writeback handshake bundle for fp_issue_ctrl.
interface fp_issue_ctrl_if;

    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;
    logic [2:0]  frm_i;
    logic        flush_i;
    logic        fpu_start_o;
    logic [3:0]  fpu_op_o;
    logic [2:0]  fpu_rm_o;
    logic [4:0]  fpu_rs1_o;
    logic [4:0]  fpu_rs2_o;
    logic        fpu_done_i;
    logic        fp_we_o;
    logic [4:0]  fp_waddr_o;
    logic        illegal_o;
    logic        timeout_o;
    logic        busy_o;

    modport slave (
        input  instr_valid_i, instr_i, frm_i, flush_i, fpu_done_i,
        output instr_ready_o, fpu_start_o, fpu_op_o, fpu_rm_o, fpu_rs1_o,
               fpu_rs2_o, fp_we_o, fp_waddr_o, illegal_o, timeout_o, busy_o
    );

    modport master (
        output instr_valid_i, instr_i, frm_i, flush_i, fpu_done_i,
        input  instr_ready_o, fpu_start_o, fpu_op_o, fpu_rm_o, fpu_rs1_o,
               fpu_rs2_o, fp_we_o, fp_waddr_o, illegal_o, timeout_o, busy_o
    );

endinterface

// File: rtl/fp_decode.sv
// Combinational OP-FP single-precision decoder: operation, rounding mode, legality.
module fp_decode
    import fpu_pkg::*;
#(
    parameter int unsigned EN_DIVSQRT = 1
) (
    input  logic [31:0] instr,
    input  logic [2:0]  frm,
    output fp_op_e      op,
    output logic [2:0]  rm,
    output logic        illegal
);

    logic [4:0] funct5;
    logic [2:0] funct3;
    logic       arith;
    logic       unused_fields;

    assign funct5        = instr[31:27];
    assign funct3        = instr[14:12];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        op      = OP_ADD;
        rm      = funct3;
        illegal = 1'b0;
        arith   = 1'b0;

        case (funct5)
            5'b00000: begin op = OP_ADD; arith = 1'b1; end
            5'b00001: begin op = OP_SUB; arith = 1'b1; end
            5'b00010: begin op = OP_MUL; arith = 1'b1; end
            5'b00011: begin
                op    = OP_DIV;
                arith = 1'b1;
                if (EN_DIVSQRT == 0) illegal = 1'b1;
            end
            5'b01011: begin
                op    = OP_SQRT;
                arith = 1'b1;
                if (EN_DIVSQRT == 0 || instr[24:20] != 5'd0) illegal = 1'b1;
            end
            5'b00100: begin
                case (funct3)
                    3'b000:  op = OP_SGNJ;
                    3'b001:  op = OP_SGNJN;
                    3'b010:  op = OP_SGNJX;
                    default: illegal = 1'b1;
                endcase
            end
            5'b00101: begin
                case (funct3)
                    3'b000:  op = OP_MIN;
                    3'b001:  op = OP_MAX;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        // Arithmetic ops resolve the dynamic mode; sign-inject/min/max keep funct3 as-is.
        if (arith) begin
            if (funct3 == RM_DYN) begin
                rm = frm;
                if (!rm_is_valid(frm)) illegal = 1'b1;
            end else if (!rm_is_valid(funct3)) begin
                illegal = 1'b1;
            end
        end

        if (instr[6:0] != OPC_OP_FP || instr[26:25] != FMT_S) illegal = 1'b1;
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue controller: accepts one FP instruction, starts the FPU, waits with
// timeout, then writes the destination register.
module fp_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned EN_DIVSQRT = 1,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst,
    fp_issue_ctrl_if.slave bus
);

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_e     state;
    logic [9:0] cnt;
    fp_op_e     op_q;
    logic [2:0] rm_q;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
    logic [4:0] rd_q;
    logic       illegal_q;
    logic       we_q;

    fp_op_e     dec_op;
    logic [2:0] dec_rm;
    logic       dec_illegal;
    logic       ready;
    logic       accept;
    logic       timeout_hit;

    fp_decode #(
        .EN_DIVSQRT(EN_DIVSQRT)
    ) u_decode (
        .instr  (bus.instr_i),
        .frm    (bus.frm_i),
        .op     (dec_op),
        .rm     (dec_rm),
        .illegal(dec_illegal)
    );

    // Ready is gated by rst so every output reads zero while reset is held.
    assign ready       = (state == ST_IDLE) & ~bus.flush_i & ~rst;
    assign accept      = bus.instr_valid_i & ready;
    assign timeout_hit = (state == ST_WAIT) & (cnt == CNT_LAST)
                       & ~bus.fpu_done_i & ~bus.flush_i;

    assign bus.instr_ready_o = ready;
    assign bus.fpu_start_o   = (state == ST_ISSUE) & ~bus.flush_i;
    assign bus.timeout_o     = timeout_hit;
    assign bus.busy_o        = (state != ST_IDLE);
    assign bus.illegal_o     = illegal_q;
    assign bus.fp_we_o       = we_q;
    assign bus.fpu_op_o      = op_q;
    assign bus.fpu_rm_o      = rm_q;
    assign bus.fpu_rs1_o     = rs1_q;
    assign bus.fpu_rs2_o     = rs2_q;
    assign bus.fp_waddr_o    = rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= OP_ADD;
            rm_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            we_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec_illegal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            op_q  <= dec_op;
                            rm_q  <= dec_rm;
                            rs1_q <= bus.instr_i[19:15];
                            rs2_q <= bus.instr_i[24:20];
                            rd_q  <= bus.instr_i[11:7];
                            cnt   <= '0;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.flush_i) begin
                        state <= ST_IDLE;
                    end else if (bus.fpu_done_i) begin
                        we_q  <= 1'b1;
                        state <= ST_WB;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flush_i) begin
                        state <= ST_IDLE;
                    end else if (bus.fpu_done_i) begin
                        we_q  <= 1'b1;
                        state <= ST_WB;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_issue_ctrl.md
FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

Interface
REQ-001 SHALL have parameter EN_DIVSQRT, default 1, meaning FDIV.S/FSQRT.S are legal; when 0 they decode as illegal.
REQ-002 SHALL have parameter TIMEOUT, default 64 (range 2..1023), meaning maximum WAIT cycles before abort.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_valid_i  input  1  instruction offered; instr_i  input  32  instruction word.
REQ-006 instr_ready_o  output  1  instruction accepted when instr_valid_i & instr_ready_o.
REQ-007 frm_i  input  3  dynamic rounding mode (fcsr.frm); flush_i  input  1  kill in-flight op.
REQ-008 fpu_start_o  output  1  one-cycle FPU start; fpu_op_o  output  4  operation code.
REQ-009 fpu_rm_o  output  3  resolved rounding mode; fpu_rs1_o, fpu_rs2_o  output  5 each  source FP registers.
REQ-010 fpu_done_i  input  1  FPU result valid.
REQ-011 fp_we_o  output  1  FP regfile write enable; fp_waddr_o  output  5  destination register.
REQ-012 illegal_o  output  1  illegal-instruction pulse; timeout_o  output  1  timeout pulse; busy_o  output  1  state != IDLE.

Function
REQ-013 Decode SHALL require opcode 1010011 and fmt=instr[26:25]=00; otherwise illegal.
REQ-014 instr[31:27]: 00000 ADD=0, 00001 SUB=1, 00010 MUL=2, 00011 DIV=3, 01011 SQRT=4 (instr[24:20] must be 0); all other codes illegal.
REQ-015 instr[31:27]=00100: funct3 000/001/010 -> SGNJ=5/SGNJN=6/SGNJX=7; 00101: funct3 000/001 -> MIN=8/MAX=9; other funct3 illegal.
REQ-016 ADD/SUB/MUL/DIV/SQRT: funct3 101/110 illegal; 111 resolves to frm_i, illegal if frm_i >= 101; otherwise rm = funct3.
REQ-017 SGNJ*/MIN/MAX: fpu_rm_o SHALL carry funct3 unchanged.
REQ-018 FSM states IDLE, ISSUE, WAIT, WB; instr_ready_o = (state==IDLE) & ~flush_i.
REQ-019 IDLE, accepted legal instr: latch op, rm, rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]; next ISSUE.
REQ-020 IDLE, accepted illegal instr: illegal_o=1 next cycle for one cycle; stay IDLE; no FPU start, no write.
REQ-021 ISSUE: fpu_start_o=1 for exactly one cycle with latched op/rm/rs1/rs2; next WAIT, or WB if fpu_done_i=1 in that cycle.
REQ-022 WAIT: 10-bit counter cleared on ISSUE entry, +1 per WAIT cycle; fpu_done_i=1 -> WB.
REQ-023 WAIT: counter == TIMEOUT-1 with fpu_done_i=0 -> timeout_o=1 one cycle, next IDLE, no write; done in same cycle wins.
REQ-024 WB: fp_we_o=1, fp_waddr_o=latched rd, one cycle; next IDLE.
REQ-025 Latency: accept cycle N -> start at N+1; done at cycle M -> fp_we_o at M+1 -> IDLE at M+2.
REQ-026 flush_i in ISSUE or WAIT -> IDLE next cycle, no write, no timeout; flush in ISSUE suppresses fpu_start_o that cycle; flush in WB ignored.
REQ-027 fpu_done_i in IDLE or WB SHALL be ignored.
REQ-028 fpu_op_o, fpu_rm_o, fpu_rs*_o, fp_waddr_o SHALL hold latched values outside ISSUE/WB.

Reset
REQ-029 rst SHALL force IDLE immediately, mid-operation included, with no write and no pulses.
REQ-030 Reset values: all outputs 0, latched fields 0, counter 0; instr_ready_o=1 once rst deasserts.

Structure
REQ-031 fpu_pkg SHALL hold fp_op_e (codes 0..9), OPC_OP_FP=1010011, FMT_S=00, and the state enum.
REQ-032 Combinational decode SHALL live in sub-module fp_decode (instr, frm, EN_DIVSQRT -> op, rm, illegal); FSM and counter in fp_issue_ctrl.

Verification
REQ-033 FADD.S f3,f1,f2 = 0x002081D3, done 3 cycles after start -> start with op=0, rm=000, rs1=1, rs2=2; fp_we_o, waddr=3 one cycle after done.
REQ-034 0x182081D3 (FDIV.S) with EN_DIVSQRT=0 -> illegal_o pulse, no start; 0x022081D3 (fmt=01) -> illegal_o pulse.
REQ-035 0x0020F1D3 (rm=111): frm_i=010 -> fpu_rm_o=010; frm_i=101 -> illegal_o pulse; 0x582081D3 (FSQRT, rs2=2) -> illegal_o.
REQ-036 TIMEOUT=4, fpu_done_i never asserted -> timeout_o on 4th WAIT cycle, no fp_we_o; done on that same cycle -> write, no timeout.
REQ-037 flush_i in WAIT, then done next cycle -> no fp_we_o; rst asserted in WAIT -> IDLE, all outputs 0 immediately.
REQ-038 Back-to-back valid instrs -> instr_ready_o=0 from ISSUE through WB; second instr accepted first IDLE cycle after WB.
